// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_ctrl
//  Purpose  : SPI mode-0 master transfer sequencer. Drives sclk/csN and
//             issues load/shift strobes to an external shift register,
//             then captures the received word from that register's parallel
//             output when the transfer completes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    width         bits per transfer (2..32)
//    clkDiv        sclk half-period in clk cycles (1..255)
//  Ports
//    clk           system clock, rising-edge active
//    resetN        asynchronous active-low reset
//    start         transfer request, honoured only while idle
//    abort         terminates an active transfer on the next edge
//    srParallelOut parallel output of the attached shift register
//    srLoad        one-cycle parallel-load strobe (first SETUP cycle)
//    srShift       one-cycle shift strobe (first cycle of each sclk high)
//    sclk          SPI clock, idles low
//    csN           active-low chip select
//    busy          high whenever the sequencer is not idle
//    done          one-cycle pulse on normal completion
//    rxData        received word, captured on entry to DONE
// ============================================================================
module spi_xfer_ctrl #(
    parameter int width  = 8,
    parameter int clkDiv = 2
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic             abort,
    input  logic [width-1:0] srParallelOut,
    output logic             srLoad,
    output logic             srShift,
    output logic             sclk,
    output logic             csN,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] rxData
);

    // Counter widths: the half-period counter only ever reaches clkDiv-1,
    // the bit counter reaches exactly width at the end of a transfer.
    localparam int PW = $clog2(clkDiv + 1);
    localparam int BW = $clog2(width + 1);

    localparam logic [PW-1:0] C_PHASE_LAST = PW'(clkDiv - 1);
    localparam logic [BW-1:0] C_BITS       = BW'(width);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [PW-1:0]    phase_q,   phase_d;
    logic [BW-1:0]    bit_q,     bit_d;

    logic             srLoad_q,  srLoad_d;
    logic             srShift_q, srShift_d;
    logic             sclk_q,    sclk_d;
    logic             csN_q,     csN_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [width-1:0] rxData_q,  rxData_d;

    logic             w_phase_last;
    logic [BW-1:0]    w_bit_next;

    assign w_phase_last = (phase_q == C_PHASE_LAST);
    assign w_bit_next   = bit_q + BW'(1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            srLoad_q  <= 1'b0;
            srShift_q <= 1'b0;
            sclk_q    <= 1'b0;
            csN_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rxData_q  <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            srLoad_q  <= srLoad_d;
            srShift_q <= srShift_d;
            sclk_q    <= sclk_d;
            csN_q     <= csN_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rxData_q  <= rxData_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (state plus the two counters)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)        state_d = ST_SETUP;
            ST_SETUP: if (w_phase_last) state_d = ST_HIGH;
            ST_HIGH:  if (w_phase_last) state_d = (w_bit_next == C_BITS) ? ST_HOLD : ST_LOW;
            ST_LOW:   if (w_phase_last) state_d = ST_HIGH;
            ST_HOLD:  if (w_phase_last) state_d = ST_DONE;
            ST_DONE:                    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase

        // Abort overrides everything outside IDLE; in IDLE it is ignored so
        // a simultaneous start still launches a transfer.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end

        // The half-period counter restarts on every phase change, which
        // also covers clkDiv=1 where each phase lasts a single cycle.
        if ((state_d == state_q) && (state_d != ST_IDLE)) begin
            phase_d = phase_q + PW'(1);
        end else begin
            phase_d = '0;
        end

        // Bit counter advances as each sclk-high phase ends.
        if ((state_d == ST_IDLE) || (state_q == ST_IDLE)) begin
            bit_d = '0;
        end else if ((state_q == ST_HIGH) && w_phase_last) begin
            bit_d = w_bit_next;
        end else begin
            bit_d = bit_q;
        end
    end

    // ------------------------------------------------------------------
    // Output logic. Values are derived from the upcoming state so that the
    // registered outputs line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        srLoad_d  = (state_d == ST_SETUP) && (state_q != ST_SETUP);
        srShift_d = (state_d == ST_HIGH)  && (state_q != ST_HIGH);
        sclk_d    = (state_d == ST_HIGH);
        csN_d     = !((state_d == ST_SETUP) || (state_d == ST_HIGH) ||
                      (state_d == ST_LOW)   || (state_d == ST_HOLD));
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);

        // Capture on entry to DONE so rxData is valid alongside done.
        rxData_d = rxData_q;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            rxData_d = srParallelOut;
        end
    end

    assign srLoad  = srLoad_q;
    assign srShift = srShift_q;
    assign sclk    = sclk_q;
    assign csN     = csN_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rxData  = rxData_q;

endmodule
`default_nettype wire
